// File: rtl/hgcal_input_packer_pkg.sv
// Shared constants and types for the HGCAL input packer: quantizer thresholds,
// quantized feature width and the frame-assembly FSM states.
package hgcal_input_packer_pkg;
    localparam int T1_DEF = 32;
    localparam int T2_DEF = 96;
    localparam int T3_DEF = 192;
    localparam int Q_W    = 2;

    typedef enum logic {
        FILL    = 1'b0,
        DISCARD = 1'b1
    } state_t;
endpackage

// File: rtl/hgcal_quantizer.sv
// Combinational 2-bit quantizer: maps an unsigned raw sample onto four
// bins split at T1/T2/T3.
module hgcal_quantizer
    import hgcal_input_packer_pkg::*;
#(
    parameter int IN_W = 8,
    parameter int T1   = T1_DEF,
    parameter int T2   = T2_DEF,
    parameter int T3   = T3_DEF
) (
    input  logic [IN_W-1:0] x,
    output logic [Q_W-1:0]  q
);
    // Widen both sides so thresholds beyond the sample range still compare correctly.
    logic [31:0] xw;
    assign xw = 32'(x);

    always_comb begin
        q = 2'd3;
        if (xw < 32'(T1))      q = 2'd0;
        else if (xw < 32'(T2)) q = 2'd1;
        else if (xw < 32'(T3)) q = 2'd2;
    end
endmodule

// File: rtl/hgcal_input_packer.sv
// Packs N_IN quantized samples into one frame word for the first LUT layer,
// dropping short frames and trimming overlong ones.
module hgcal_input_packer
    import hgcal_input_packer_pkg::*;
#(
    parameter int N_IN = 4,
    parameter int IN_W = 8,
    parameter int T1   = T1_DEF,
    parameter int T2   = T2_DEF,
    parameter int T3   = T3_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [IN_W-1:0]       s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [Q_W*N_IN-1:0]   m_data,
    output logic                  err_short,
    output logic                  err_long,
    output logic [15:0]           frame_cnt
);
    localparam int IDX_W = $clog2(N_IN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

    state_t                    state, state_nx;
    logic [IDX_W-1:0]          idx;
    logic [N_IN-1:0][Q_W-1:0]  fill, fill_merge, out_q;
    logic [Q_W-1:0]            q;
    logic                      accept, fill_beat, at_last, load;

    hgcal_quantizer #(.IN_W(IN_W), .T1(T1), .T2(T2), .T3(T3)) u_quant (
        .x (s_data),
        .q (q)
    );

    assign accept    = s_valid && s_ready;
    assign fill_beat = accept && (state == FILL);
    assign at_last   = (idx == LAST_IDX);
    assign load      = fill_beat && at_last;
    assign m_data    = out_q;

    always_ff @(posedge clk) begin
        if (!rst) state <= FILL;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            FILL:    if (load && !s_last)   state_nx = DISCARD;
            DISCARD: if (accept && s_last)  state_nx = FILL;
            default: state_nx = FILL;
        endcase
    end

    // Stall only the frame-completing beat, and only while the output slot is occupied.
    always_comb begin
        s_ready = !((state == FILL) && at_last && m_valid && !m_ready);
    end

    // The final beat bypasses the fill buffer so the frame loads in the same cycle.
    always_comb begin
        fill_merge      = fill;
        fill_merge[idx] = q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx       <= '0;
            fill      <= '0;
            out_q     <= '0;
            m_valid   <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            err_short <= fill_beat && !at_last && s_last;
            err_long  <= load && !s_last;
            if (fill_beat) begin
                fill[idx] <= q;
                idx       <= (at_last || s_last) ? '0 : idx + 1'b1;
            end
            if (load) begin
                out_q   <= fill_merge;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            if (m_valid && m_ready) frame_cnt <= frame_cnt + 16'd1;
        end
    end
endmodule
